// File: rtl/pipe_pkg.sv
// Shared definitions for the memory-access pipeline stage.
//   LEN_B/H/W/D : access size encodings carried on up_len.
//   ma_state_t  : control state of pipe_ma_stage.
//   misaligned(): true when the byte offset is not a multiple of the size.
package pipe_pkg;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;
  localparam logic [1:0] LEN_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    HOLD = 2'd2
  } ma_state_t;

  // For LEN_D, (1 << 3) wraps to 0 in three bits, so the mask becomes 3'b111.
  function automatic logic misaligned(input logic [1:0] len, input logic [2:0] off);
    logic [2:0] m;
    m = (3'd1 << len) - 3'd1;
    return (off & m) != 3'd0;
  endfunction

endpackage

// File: rtl/pipe_ma_stage_if.sv
// Memory bus between pipe_ma_stage and the data memory.
//   master (stage) : drives mem_req/mem_we/mem_addr/mem_wdata/mem_be,
//                    receives mem_gnt/mem_rvalid/mem_rdata.
//   slave (memory) : the reverse directions.
interface pipe_ma_stage_if #(
  parameter int MADDR_L = 32,
  parameter int DATA_L  = 32
) ();

  logic                  mem_req;
  logic                  mem_we;
  logic [MADDR_L-1:0]    mem_addr;
  logic [DATA_L-1:0]     mem_wdata;
  logic [DATA_L/8-1:0]   mem_be;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_L-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/ma_lane_align.sv
// Combinational byte-lane steering for the memory-access stage.
//   len/off   : access size and byte offset inside the bus word.
//   uns       : zero-extend (1) or sign-extend (0) load data.
//   wdata     : right-aligned store data -> wdata_rep, replicated on all lanes.
//   rdata     : full-width read data     -> rdata_ext, selected lane extended.
//   be        : byte enables, 2^len ones starting at bit off.
module ma_lane_align
  import pipe_pkg::*;
#(
  parameter int DATA_L = 32
) (
  input  logic [1:0]                  len,
  input  logic [$clog2(DATA_L/8)-1:0] off,
  input  logic                        uns,
  input  logic [DATA_L-1:0]           wdata,
  input  logic [DATA_L-1:0]           rdata,
  output logic [DATA_L/8-1:0]         be,
  output logic [DATA_L-1:0]           wdata_rep,
  output logic [DATA_L-1:0]           rdata_ext
);

  localparam int NB = DATA_L / 8;

  logic [NB-1:0]      mask;
  logic [DATA_L-1:0]  rshift;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;
  logic signed [31:0] lane_w;

  // Bring the addressed lane down to bit 0 before extension.
  assign rshift = rdata >> {off, 3'b000};
  assign lane_b = rshift[7:0];
  assign lane_h = rshift[15:0];
  assign lane_w = rshift[31:0];

  always_comb begin
    mask      = '1;
    wdata_rep = wdata;
    rdata_ext = rshift;
    case (len)
      LEN_B: begin
        mask      = NB'(1);
        wdata_rep = {NB{wdata[7:0]}};
        rdata_ext = uns ? DATA_L'(rshift[7:0]) : DATA_L'(lane_b);
      end
      LEN_H: begin
        mask      = NB'(3);
        wdata_rep = {(NB/2){wdata[15:0]}};
        rdata_ext = uns ? DATA_L'(rshift[15:0]) : DATA_L'(lane_h);
      end
      LEN_W: begin
        mask      = NB'(15);
        wdata_rep = {(NB/4){wdata[31:0]}};
        rdata_ext = uns ? DATA_L'(rshift[31:0]) : DATA_L'(lane_w);
      end
      default: begin
        // Full-width dword access: only reachable legally with DATA_L=64.
        mask      = '1;
        wdata_rep = wdata;
        rdata_ext = rshift;
      end
    endcase
  end

  assign be = mask << off;

endmodule

// File: rtl/pipe_ma_stage.sv
// Memory-access pipeline stage: accepts one op from upstream, performs at
// most one memory transaction for it, and holds the writeback result until
// downstream takes it.
//   clk, rst            : clock, asynchronous active-high reset.
//   up_*                : upstream op (valid/ready handshake).
//   down_valid/ready    : downstream result handshake.
//   wb_e/wb_idx/wb_data : writeback enable, register index and data.
//   fault               : misaligned or illegal access.
//   mem                 : memory bus (master side).
module pipe_ma_stage
  import pipe_pkg::*;
#(
  parameter int MADDR_L = 32,
  parameter int DATA_L  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic                 up_re,
  input  logic                 up_we,
  input  logic [1:0]           up_len,
  input  logic                 up_uns,
  input  logic [4:0]           up_rd,
  input  logic                 up_wb_e,
  input  logic [MADDR_L-1:0]   up_addr,
  input  logic [DATA_L-1:0]    up_wdata,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic                 wb_e,
  output logic [4:0]           wb_idx,
  output logic [DATA_L-1:0]    wb_data,
  output logic                 fault,
  pipe_ma_stage_if.master      mem
);

  localparam int NB    = DATA_L / 8;
  localparam int OFF_W = $clog2(NB);

  ma_state_t           state;
  logic                up_ready_q;
  logic                down_valid_q;
  logic                wb_e_q;
  logic [4:0]          wb_idx_q;
  logic [DATA_L-1:0]   wb_data_q;
  logic                fault_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [MADDR_L-1:0]  mem_addr_q;
  logic [DATA_L-1:0]   mem_wdata_q;
  logic [NB-1:0]       mem_be_q;
  logic                gnt_seen;

  // Op fields kept for the MEM state.
  logic                op_we;
  logic [1:0]          op_len;
  logic                op_uns;
  logic [OFF_W-1:0]    op_off;

  logic                is_mem;
  logic                up_fault;
  logic                accept;
  logic                gnt_now;
  logic [1:0]          lane_len;
  logic [OFF_W-1:0]    lane_off;
  logic                lane_uns;
  logic [NB-1:0]       lane_be;
  logic [DATA_L-1:0]   lane_wdata;
  logic [DATA_L-1:0]   lane_rdata;

  assign is_mem   = up_re | up_we;
  assign up_fault = is_mem &&
                    ((up_re && up_we) ||
                     (up_len == LEN_D && DATA_L == 32) ||
                     misaligned(up_len, 3'(up_addr[OFF_W-1:0])));
  assign accept   = (state == IDLE) && up_ready_q && up_valid;
  // A grant counts only while the request is still outstanding.
  assign gnt_now  = mem_req_q && mem.mem_gnt;

  // One aligner serves both directions: in IDLE it sees the incoming op to
  // build byte enables and store data; afterwards it sees the captured op to
  // extract load data.
  assign lane_len = (state == IDLE) ? up_len : op_len;
  assign lane_off = (state == IDLE) ? up_addr[OFF_W-1:0] : op_off;
  assign lane_uns = (state == IDLE) ? up_uns : op_uns;

  ma_lane_align #(.DATA_L(DATA_L)) u_align (
    .len       (lane_len),
    .off       (lane_off),
    .uns       (lane_uns),
    .wdata     (up_wdata),
    .rdata     (mem.mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      up_ready_q   <= 1'b0;
      down_valid_q <= 1'b0;
      wb_e_q       <= 1'b0;
      wb_idx_q     <= '0;
      wb_data_q    <= '0;
      fault_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      gnt_seen     <= 1'b0;
      op_we        <= 1'b0;
      op_len       <= LEN_B;
      op_uns       <= 1'b0;
      op_off       <= '0;
    end else begin
      case (state)
        // Accept boundary: capture the op and decide MEM or HOLD.
        IDLE: begin
          up_ready_q <= 1'b1;
          if (accept) begin
            up_ready_q <= 1'b0;
            wb_idx_q   <= up_rd;
            op_we      <= up_we;
            op_len     <= up_len;
            op_uns     <= up_uns;
            op_off     <= up_addr[OFF_W-1:0];
            if (up_fault) begin
              fault_q      <= 1'b1;
              wb_e_q       <= 1'b0;
              wb_data_q    <= '0;
              down_valid_q <= 1'b1;
              state        <= HOLD;
            end else if (is_mem) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= up_we;
              mem_addr_q  <= {up_addr[MADDR_L-1:OFF_W], OFF_W'(0)};
              mem_wdata_q <= lane_wdata;
              mem_be_q    <= lane_be;
              gnt_seen    <= 1'b0;
              state       <= MEM;
            end else begin
              wb_e_q       <= up_wb_e;
              wb_data_q    <= DATA_L'(up_addr);
              down_valid_q <= 1'b1;
              state        <= HOLD;
            end
          end
        end

        // Memory boundary: request until granted, loads also wait for data.
        MEM: begin
          if (gnt_now) begin
            mem_req_q <= 1'b0;
            gnt_seen  <= 1'b1;
          end
          if (op_we) begin
            if (gnt_now) begin
              wb_e_q       <= 1'b0;
              down_valid_q <= 1'b1;
              state        <= HOLD;
            end
          end else if ((gnt_now || gnt_seen) && mem.mem_rvalid) begin
            mem_req_q    <= 1'b0;
            wb_e_q       <= 1'b1;
            wb_data_q    <= lane_rdata;
            down_valid_q <= 1'b1;
            state        <= HOLD;
          end
        end

        // Result boundary: hold until downstream accepts.
        HOLD: begin
          if (down_ready) begin
            down_valid_q <= 1'b0;
            wb_e_q       <= 1'b0;
            fault_q      <= 1'b0;
            up_ready_q   <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          state        <= IDLE;
          mem_req_q    <= 1'b0;
          down_valid_q <= 1'b0;
          wb_e_q       <= 1'b0;
          fault_q      <= 1'b0;
          up_ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign up_ready      = up_ready_q;
  assign down_valid    = down_valid_q;
  assign wb_e          = wb_e_q;
  assign wb_idx        = wb_idx_q;
  assign wb_data       = wb_data_q;
  assign fault         = fault_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;

endmodule

// File: doc/pipe_ma_stage.md
PIPE_MA_STAGE -- requirements
Module: pipe_ma_stage

Interface
REQ-001 MADDR_L, 32, byte-address width.
REQ-002 DATA_L, 32, data width; legal values 32 or 64.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 up_valid  in  1  upstream op valid.
REQ-006 up_ready  out  1  stage can accept an op.
REQ-007 up_re  in  1  load op.
REQ-008 up_we  in  1  store op.
REQ-009 up_len  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-010 up_uns  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 up_rd  in  5  destination register index.
REQ-012 up_wb_e  in  1  non-memory op writes back.
REQ-013 up_addr  in  MADDR_L  effective address, or ALU result for non-memory ops.
REQ-014 up_wdata  in  DATA_L  store data, right-aligned.
REQ-015 down_valid  out  1  result valid.
REQ-016 down_ready  in  1  downstream accepts result.
REQ-017 wb_e  out  1  writeback enable.
REQ-018 wb_idx  out  5  writeback register index.
REQ-019 wb_data  out  DATA_L  writeback data.
REQ-020 fault  out  1  misaligned or illegal access.
REQ-021 mem_req  out  1  memory request.
REQ-022 mem_we  out  1  request is a write.
REQ-023 mem_addr  out  MADDR_L  address aligned down to DATA_L/8 bytes.
REQ-024 mem_wdata  out  DATA_L  store data replicated across all lanes.
REQ-025 mem_be  out  DATA_L/8  byte enables.
REQ-026 mem_gnt  in  1  request accepted this cycle.
REQ-027 mem_rvalid  in  1  read data valid; may coincide with mem_gnt or follow it.
REQ-028 mem_rdata  in  DATA_L  full-width read data.

Function
REQ-029 States: IDLE, MEM, HOLD; up_ready=1 only in IDLE, down_valid=1 only in HOLD.
REQ-030 IDLE and up_valid: register all up_* fields. Aligned legal load/store -> MEM; any other op -> HOLD.
REQ-031 Alignment: address offset is a multiple of 2^up_len. Violations, up_len=3 with DATA_L=32, or re&we all set fault=1, wb_e=0, issue no mem_req, and go to HOLD.
REQ-032 MEM: mem_req held at 1 with stable mem_* until mem_gnt. Store -> HOLD on the gnt cycle. Load -> HOLD on the first cycle with mem_gnt seen (this or an earlier cycle) and mem_rvalid.
REQ-033 mem_be: 2^up_len ones starting at bit addr[log2(DATA_L/8)-1:0].
REQ-034 Load data: extract the lane at that offset, then zero- or sign-extend it to DATA_L per up_uns; captured into wb_data.
REQ-035 Non-memory op: wb_data=up_addr, wb_e=up_wb_e. Legal load: wb_e=1. Store: wb_e=0.
REQ-036 HOLD: wb_*, fault and down_valid are stable until down_ready. down_valid&down_ready -> IDLE and down_valid=0 the next cycle.
REQ-037 Latency: non-mem or fault op accepted at cycle N gives down_valid at N+1. A load with gnt and rvalid in the first MEM cycle gives down_valid at N+2.
REQ-038 Throughput: at most one op per 2 cycles; no accept while in MEM or HOLD.
REQ-039 wb_e, fault and mem_req are 0 outside the states that drive them.

Reset
REQ-040 rst, including mid-MEM: state=IDLE and every output 0 (up_ready becomes 1 after the first clock with rst low); an outstanding memory request is abandoned.

Structure
REQ-041 Shared package pipe_pkg holds the len encodings (LEN_B/H/W/D) and the state enum.
REQ-042 One sub-module, ma_lane_align, is combinational and produces mem_be, replicated wdata and extended load data.

Verification (DATA_L=32)
REQ-043 Non-mem op with up_addr=0x1234, rd=5, wb_e=1: down_valid next cycle, wb_data=0x1234, wb_idx=5, mem_req never asserted.
REQ-044 Store byte to 0x103 with data 0xAB and mem_gnt delayed 3 cycles: mem_addr=0x100, mem_be=4'b1000, mem_wdata=0xABABABAB, mem_req held stable for 4 cycles.
REQ-045 Load half from 0x102 with mem_rdata=0x80010000: up_uns=0 gives wb_data=0xFFFF8001; up_uns=1 gives 0x00008001.
REQ-046 Load word from 0x101: fault=1, wb_e=0, mem_req stays 0, down_valid at N+1.
REQ-047 Hold down_ready=0 for 4 cycles in HOLD: outputs stable and up_ready=0. Assert rst during MEM: all outputs 0 at once, then IDLE.
